// File: rtl/clk_freq_meter_pkg.sv
// -----------------------------------------------------------------------------
// clk_freq_meter_pkg
// Shared definitions for the clock frequency meter:
//   state_t      - measurement FSM states (IDLE, ARM, MEASURE)
//   SETTLE_DEPTH - consecutive enabled CLK cycles required before arming, so
//                  that the Gray synchronizer pipeline holds current data
//   CDC_STAGES   - flop count of each synchronizer chain
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package clk_freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    localparam int unsigned SETTLE_DEPTH = 3;
    localparam int unsigned CDC_STAGES   = 2;

endpackage

// File: rtl/gray_sync_counter.sv
// -----------------------------------------------------------------------------
// gray_sync_counter
// Counts MEAS_CLK edges (after an optional power-of-two prescaler) in the
// MEAS_CLK domain, publishes the count as Gray code, and brings it into the
// CLK domain through a flop chain followed by Gray->binary conversion.
//
// Ports:
//   CLK      in   reference clock (snap_o domain)
//   RESET    in   asynchronous active-low reset; synchronized into MEAS_CLK
//   MEAS_CLK in   clock under test
//   snap_o   out  CNT_W  binary count of prescaled MEAS_CLK ticks, CLK domain
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module gray_sync_counter
    import clk_freq_meter_pkg::*;
#(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned PRESC_LOG2 = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             MEAS_CLK,
    output logic [CNT_W-1:0] snap_o
);

    // MEAS_CLK-domain reset: asserts immediately, releases on the second
    // MEAS_CLK edge after RESET rises.
    logic [CDC_STAGES-1:0] mrst_q;
    logic                  mrst_n;

    always_ff @(posedge MEAS_CLK or negedge RESET) begin
        if (!RESET) begin
            mrst_q <= '0;
        end else begin
            mrst_q <= {mrst_q[CDC_STAGES-2:0], 1'b1};
        end
    end

    assign mrst_n = mrst_q[CDC_STAGES-1];

    // Prescaler: tick once per 2^PRESC_LOG2 MEAS_CLK edges.
    logic tick;

    generate
        if (PRESC_LOG2 == 0) begin : g_nopresc
            assign tick = 1'b1;
        end else begin : g_presc
            logic [PRESC_LOG2-1:0] presc_q;

            always_ff @(posedge MEAS_CLK or negedge mrst_n) begin
                if (!mrst_n) begin
                    presc_q <= '0;
                end else begin
                    presc_q <= presc_q + 1'b1;
                end
            end

            assign tick = &presc_q;
        end
    endgenerate

    logic [CNT_W-1:0] bin_q;
    logic [CNT_W-1:0] bin_d;
    logic [CNT_W-1:0] gray_q;

    assign bin_d = bin_q + 1'b1;

    // Gray register is loaded from the incremented value so that it always
    // encodes the same count as bin_q; only one bit changes per tick.
    always_ff @(posedge MEAS_CLK or negedge mrst_n) begin
        if (!mrst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else if (tick) begin
            bin_q  <= bin_d;
            gray_q <= bin_d ^ (bin_d >> 1);
        end
    end

    // CLK-domain synchronizer chain for the Gray word.
    logic [CNT_W-1:0] sync_q [CDC_STAGES];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int unsigned i = 0; i < CDC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gray_q;
            for (int unsigned i = 1; i < CDC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Gray->binary: bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        snap_o = '0;
        for (int unsigned i = 0; i < CNT_W; i++) begin
            snap_o[i] = ^(sync_q[CDC_STAGES-1] >> i);
        end
    end

endmodule

// File: rtl/clk_freq_meter.sv
// -----------------------------------------------------------------------------
// clk_freq_meter
// Measures the frequency of MEAS_CLK against CLK: counts prescaled MEAS_CLK
// edges over back-to-back windows of GATE_CYCLES CLK cycles and reports one
// result per window.
//
// Ports:
//   CLK          in   reference clock; all outputs in this domain
//   RESET        in   asynchronous active-low reset
//   MEAS_CLK     in   clock under test, asynchronous to CLK
//   enable       in   1 = measure continuously, 0 = return to IDLE
//   freq_count   out  CNT_W  prescaled edge count of last completed window
//   freq_valid   out  one-cycle pulse when freq_count updates
//   stalled      out  last completed window counted 0
//
// Optional (macro FREQ_METER_ALARM_EN):
//   freq_min     in   CNT_W  lower bound for an in-range result
//   freq_max     in   CNT_W  upper bound for an in-range result
//   out_of_range out  result < freq_min or > freq_max, updated with freq_valid
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module clk_freq_meter
    import clk_freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 12000000,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned PRESC_LOG2  = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             MEAS_CLK,
    input  logic             enable,
`ifdef FREQ_METER_ALARM_EN
    input  logic [CNT_W-1:0] freq_min,
    input  logic [CNT_W-1:0] freq_max,
    output logic             out_of_range,
`endif
    output logic [CNT_W-1:0] freq_count,
    output logic             freq_valid,
    output logic             stalled
);

    localparam int unsigned GW = $clog2(GATE_CYCLES);
    localparam int unsigned SW = $clog2(SETTLE_DEPTH);

    logic [CNT_W-1:0] snap;

    gray_sync_counter #(
        .CNT_W      (CNT_W),
        .PRESC_LOG2 (PRESC_LOG2)
    ) u_gray_sync_counter (
        .CLK      (CLK),
        .RESET    (RESET),
        .MEAS_CLK (MEAS_CLK),
        .snap_o   (snap)
    );

    state_t           state_q,   state_d;
    logic [SW-1:0]    settle_q,  settle_d;
    logic [GW-1:0]    gate_q,    gate_d;
    logic [CNT_W-1:0] prev_q,    prev_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic             valid_q,   valid_d;
    logic             stalled_q, stalled_d;
    logic             oor_q,     oor_d;
    logic [CNT_W-1:0] diff;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            settle_q  <= '0;
            gate_q    <= '0;
            prev_q    <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            stalled_q <= 1'b0;
            oor_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            gate_q    <= gate_d;
            prev_q    <= prev_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            stalled_q <= stalled_d;
            oor_q     <= oor_d;
        end
    end

    always_comb begin
        // Modulo subtraction makes counter wrap inside a window transparent.
        diff      = snap - prev_q;
        state_d   = state_q;
        settle_d  = '0;
        gate_d    = '0;
        prev_d    = prev_q;
        count_d   = count_q;
        valid_d   = 1'b0;
        stalled_d = stalled_q;
        oor_d     = oor_q;

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Third consecutive enabled cycle arms the meter.
                    if (settle_q == SW'(SETTLE_DEPTH - 1)) begin
                        state_d = ST_ARM;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                ST_ARM: begin
                    prev_d  = snap;
                    state_d = ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (gate_q == GW'(GATE_CYCLES - 1)) begin
                        // Window closes; the next one starts on this same edge.
                        count_d   = diff;
                        prev_d    = snap;
                        valid_d   = 1'b1;
                        stalled_d = (diff == '0);
`ifdef FREQ_METER_ALARM_EN
                        oor_d     = (diff < freq_min) || (diff > freq_max);
`endif
                    end else begin
                        gate_d = gate_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign freq_count = count_q;
    assign freq_valid = valid_q;
    assign stalled    = stalled_q;

`ifdef FREQ_METER_ALARM_EN
    assign out_of_range = oor_q;
`else
    logic unused_oor;
    assign unused_oor = oor_q;
`endif

endmodule

// File: tb/tb_clk_freq_meter.sv
`timescale 1ns/1ps
module tb_clk_freq_meter;

    localparam int G  = 100;
    localparam int W0 = 8;
    localparam int W1 = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic m0    = 1'b0;
    logic m1    = 1'b0;
    logic enable = 1'b0;
    logic run0  = 1'b1;
    logic [31:0] fmin = 32'd45;
    logic [31:0] fmax = 32'd60;

    logic [W0-1:0] cnt0;
    logic          v0, st0;
    logic [W1-1:0] cnt1;
    logic          v1, st1;
`ifdef FREQ_METER_ALARM_EN
    logic          oor0, oor1;
`endif

    int checks   = 0;
    int failures = 0;

    // CLK posedges at 5 mod 10 ns; MEAS clocks never share an edge time with CLK.
    always #5 clk = ~clk;
    initial begin
        #3;
        forever begin
            #12.5;
            m0 = run0 ? ~m0 : 1'b0;
        end
    end
    initial begin
        #1;
        forever #2.5 m1 = ~m1;
    end

    clk_freq_meter #(.GATE_CYCLES(G), .CNT_W(W0), .PRESC_LOG2(0)) u_dut0 (
        .CLK(clk), .RESET(rst_n), .MEAS_CLK(m0), .enable(enable),
`ifdef FREQ_METER_ALARM_EN
        .freq_min(fmin[W0-1:0]), .freq_max(fmax[W0-1:0]), .out_of_range(oor0),
`endif
        .freq_count(cnt0), .freq_valid(v0), .stalled(st0)
    );

    clk_freq_meter #(.GATE_CYCLES(G), .CNT_W(W1), .PRESC_LOG2(2)) u_dut1 (
        .CLK(clk), .RESET(rst_n), .MEAS_CLK(m1), .enable(enable),
`ifdef FREQ_METER_ALARM_EN
        .freq_min(fmin), .freq_max(fmax), .out_of_range(oor1),
`endif
        .freq_count(cnt1), .freq_valid(v1), .stalled(st1)
    );

    // ---------------- reference model ----------------
    // Edge counts per clock under test; the meter's own reset releases on the
    // second MEAS edge after RESET rises, so the first two edges are not counted.
    longint mc0 = 0, mc1 = 0;
    int     seen0 = 0, seen1 = 0;

    always @(posedge m0) begin
        if (!rst_n) begin seen0 = 0; mc0 = 0; end
        else begin seen0++; if (seen0 >= 3) mc0++; end
    end
    always @(posedge m1) begin
        if (!rst_n) begin seen1 = 0; mc1 = 0; end
        else begin seen1++; if (seen1 >= 3) mc1++; end
    end
    always @(negedge rst_n) begin
        mc0 = 0; seen0 = 0; mc1 = 0; seen1 = 0;
    end

    longint hist [2][256];
    longint msk  [2] = '{64'd255, 64'hFFFF_FFFF};
    int     psh  [2] = '{0, 2};
    int     k = 0;
    int     n = 0;
    logic   exp_valid = 1'b0;
    longint exp_cnt [2] = '{0, 0};
    int     exp_st  [2] = '{0, 0};   // 0/1 expected, 2 = ambiguous within tolerance
    int     exp_oor [2] = '{0, 0};

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_tol(input string name, input longint got, input longint exp, input longint m);
        longint d;
        d = (got - exp) & m;
        checks++;
        if (!(d == 0 || d == 1 || d == m)) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d+-1 at %0t", name, got, exp, $time);
        end
    endtask

    // Model step at every CLK edge, then compare shortly after the edge.
    // A result reflects MEAS edges seen two CLK edges earlier (sync latency),
    // over a window of G cycles ending on the pulse edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            n = 0;
            exp_valid = 1'b0;
            for (int i = 0; i < 2; i++) begin
                exp_cnt[i] = 0; exp_st[i] = 0; exp_oor[i] = 0;
            end
        end else begin
            n = enable ? n + 1 : 0;
            hist[0][k % 256] = mc0;
            hist[1][k % 256] = mc1;
            exp_valid = (n > 4) && ((n - 4) % G == 0);
            if (exp_valid) begin
                for (int i = 0; i < 2; i++) begin
                    longint a, b, lo, hi;
                    a = hist[i][(k - 2) % 256] >> psh[i];
                    b = hist[i][(k - 2 - G) % 256] >> psh[i];
                    exp_cnt[i] = (a - b) & msk[i];
                    exp_st[i]  = (exp_cnt[i] == 0) ? 1 : ((exp_cnt[i] >= 2) ? 0 : 2);
                    lo = exp_cnt[i] - 1;
                    hi = exp_cnt[i] + 1;
                    if (hi < longint'(fmin) || lo > longint'(fmax)) exp_oor[i] = 1;
                    else if (lo >= longint'(fmin) && hi <= longint'(fmax)) exp_oor[i] = 0;
                    else exp_oor[i] = 2;
                end
            end
        end
        k++;
        #1;
        chk("valid0", longint'(v0), longint'(exp_valid));
        chk("valid1", longint'(v1), longint'(exp_valid));
        chk_tol("count0", longint'(cnt0), exp_cnt[0], msk[0]);
        chk_tol("count1", longint'(cnt1), exp_cnt[1], msk[1]);
        if (exp_st[0] != 2) chk("stalled0", longint'(st0), exp_st[0]);
        if (exp_st[1] != 2) chk("stalled1", longint'(st1), exp_st[1]);
`ifdef FREQ_METER_ALARM_EN
        if (exp_oor[0] != 2) chk("oor0", longint'(oor0), exp_oor[0]);
        if (exp_oor[1] != 2) chk("oor1", longint'(oor1), exp_oor[1]);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic wait_pulse(output int lat);
        lat = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #2;
            if (v0) begin lat = i; break; end
        end
        checks++;
        if (lat < 0) begin
            failures++;
            $display("FAIL pulse_timeout: got none expected freq_valid within 300 cycles");
        end
    endtask

    initial begin
        int lat, r;
        repeat (3) @(negedge clk);
        chk("reset_count0", longint'(cnt0), 0);
        chk("reset_valid0", longint'(v0), 0);
        chk("reset_stalled0", longint'(st0), 0);
        chk("reset_count1", longint'(cnt1), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Continuous measurement: latency, rate, wrap-free results.
        enable = 1'b1;
        wait_pulse(lat);
        chk("first_latency", lat, 104);
        chk_tol("first_count0", longint'(cnt0), 40, msk[0]);
        chk_tol("first_count1", longint'(cnt1), 50, msk[1]);
        chk_tol("model_pin0", exp_cnt[0], 40, msk[0]);
        chk_tol("model_pin1", exp_cnt[1], 50, msk[1]);
`ifdef FREQ_METER_ALARM_EN
        chk("oor_below_min", longint'(oor0), 1);
        chk("oor_in_range1", longint'(oor1), 0);
`endif
        for (int w = 0; w < 20; w++) begin
            wait_pulse(lat);
            chk("period", lat, G);
            chk_tol("wrap_count0", longint'(cnt0), 40, msk[0]);
        end
        @(negedge clk) fmin = 32'd30;
        wait_pulse(lat);
`ifdef FREQ_METER_ALARM_EN
        chk("oor_cleared", longint'(oor0), 0);
`endif

        // Stall the clock under test mid-window, then restart it.
        r = $urandom_range(90, 10);
        repeat (r) @(negedge clk);
        run0 = 1'b0;
        wait_pulse(lat);
        wait_pulse(lat);
        chk("stall_count", longint'(cnt0), 0);
        chk("stall_flag", longint'(st0), 1);
        wait_pulse(lat);
        chk("stall_flag2", longint'(st0), 1);
        r = $urandom_range(90, 10);
        repeat (r) @(negedge clk);
        run0 = 1'b1;
        wait_pulse(lat);
        wait_pulse(lat);
        chk_tol("restart_count", longint'(cnt0), 40, msk[0]);
        chk("restart_flag", longint'(st0), 0);

        // Reset mid-window.
        r = $urandom_range(70, 30);
        repeat (r) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_count0", longint'(cnt0), 0);
        chk("midreset_count1", longint'(cnt1), 0);
        chk("midreset_valid", longint'(v0), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_pulse(lat);
        chk("post_reset_latency", lat, 104);

        // Enable dropped across the point where a pulse was due.
        r = $urandom_range(80, 20);
        repeat (r) @(negedge clk);
        enable = 1'b0;
        repeat (G - r + $urandom_range(20, 5)) @(negedge clk);
        chk_tol("hold_count", longint'(cnt0), 40, msk[0]);
        enable = 1'b1;
        wait_pulse(lat);
        chk("reenable_latency", lat, 104);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_freq_meter.md
Name: clk_freq_meter

Overview:
Measures the frequency of a design clock (e.g. PLL output or divided clock) against the board's reference clock.
- Counts MEAS_CLK edges over a fixed gate window of CLK cycles.
- Transfers the count across domains with a Gray-coded counter and reports one result per window.
- Used for bring-up and as a sanity check that clock generation produced the requested frequency.

Parameters:
GATE_CYCLES, 12000000, gate window length in CLK cycles (12 MHz board clock gives 1 s, so result = Hz)
CNT_W, 32, width of the MEAS_CLK counter and of freq_count; results are modulo 2^CNT_W
PRESC_LOG2, 0, MEAS_CLK prescaler; the counter advances once every 2^PRESC_LOG2 MEAS_CLK edges

Ports:
CLK  in  1  reference clock; all outputs are in this domain
RESET  in  1  reset, asynchronous, active-low; clock CLK
MEAS_CLK  in  1  clock under test, asynchronous to CLK
enable  in  1  1 = measure continuously; 0 = return to IDLE
freq_count  out  CNT_W  prescaled edge count of the last completed window
freq_valid  out  1  one-CLK-cycle pulse when freq_count updates
stalled  out  1  last completed window counted 0

Behaviour:
- Reset (RESET=0): asynchronous clear of all CLK-domain state. freq_count=0, freq_valid=0, stalled=0, FSM=IDLE.
- MEAS_CLK-domain reset: RESET passes through a 2-flop synchronizer in MEAS_CLK (async assert, sync deassert). It clears the prescaler and the binary and Gray counters.
- MEAS_CLK domain:
  - Prescaler counts 0..2^PRESC_LOG2-1.
  - On wrap, binary counter +1 (modulo 2^CNT_W) and Gray register <= bin ^ (bin>>1), both registered.
- CDC: each Gray bit passes through 2 flops in CLK, then is converted Gray->binary (combinational) to give snap.
  - Constraint: MEAS_CLK/2^PRESC_LOG2 < CLK/2. Outside this the result is undefined.
- FSM (CLK domain):
  - IDLE: gate counter=0. Leave when enable=1 and the settle counter has seen 3 consecutive enabled cycles (CDC flush). Go to ARM.
  - ARM: prev <= snap; gate counter=0. Go to MEASURE next cycle.
  - MEASURE: gate counter +1 each cycle. At gate counter == GATE_CYCLES-1:
    - freq_count <= snap - prev, modulo 2^CNT_W (counter wrap is transparent).
    - prev <= snap.
    - freq_valid=1 for that one cycle.
    - stalled <= (difference == 0).
    - Gate counter -> 0; stay in MEASURE. Windows run back to back with no dead cycles.
- enable=0 in any state: next state IDLE, settle counter cleared. freq_count and stalled hold; no freq_valid.
- RESET asserted mid-window: partial count is discarded, outputs go to reset values.
- Latency: first freq_valid on cycle 3+1+GATE_CYCLES after enable is sampled high. Later pulses every GATE_CYCLES cycles.
- Accuracy: ±1 count per window from synchronizer sampling uncertainty.
- Gate counter width is $clog2(GATE_CYCLES). GATE_CYCLES >= 2 is required.

Optional Feature:
Macro FREQ_METER_ALARM_EN.
- Defined: adds ports freq_min (in, CNT_W), freq_max (in, CNT_W) and out_of_range (out, 1, reset 0).
  - out_of_range is updated in the same cycle as freq_valid: 1 if result < freq_min or result > freq_max (unsigned compare against the new result), else 0.
  - Holds between windows.
- Undefined: these ports and the logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package: FSM state encoding (IDLE, ARM, MEASURE), settle depth constant (3), CDC stage count constant (2).
- One sub-module: gray_sync_counter. It holds the MEAS_CLK-domain prescaler, binary/Gray counter and reset synchronizer, plus the CLK-domain 2-flop Gray sync and Gray->binary conversion. It outputs snap.
- FSM, subtraction and alarm logic stay in clk_freq_meter.

Test Plan:
- Defaults except GATE_CYCLES=100, CLK 10 ns, MEAS_CLK 25 ns, enable=1 -> freq_valid pulses every 100 cycles, freq_count=40±1, stalled=0, first pulse at cycle 104.
- CNT_W=8, same clocks, run 20 windows (counter wraps several times) -> every result 40±1, never a wrap artifact such as 216.
- MEAS_CLK held low after window 2 -> window 3 count below 40, window 4 onward freq_count=0 with stalled=1. MEAS_CLK restarts -> next full window 40±1 with stalled=0.
- PRESC_LOG2=2, MEAS_CLK 5 ns, CLK 10 ns, GATE_CYCLES=100 -> freq_count=50±1.
- RESET pulsed low at cycle 50 of a window -> outputs 0 immediately, no pulse for the aborted window, next freq_valid 104 cycles after release. enable dropped mid-window -> no pulse, freq_count holds.
- FREQ_METER_ALARM_EN, freq_min=45, freq_max=60, count 40 -> out_of_range=1 with freq_valid. Change to freq_max=60, freq_min=30 -> 0 on next pulse.
